// File: rtl/mult_8bit_seq_if.sv
// Handshake bundle between the control unit and the sequential multiplier.
// The control unit drives start and operands; the multiplier reports status and result.
interface mult_8bit_seq_if;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] Product;
  logic        Overflow;

  modport master (
    output start, A, B,
    input  busy, done, Product, Overflow
  );

  modport slave (
    input  start, A, B,
    output busy, done, Product, Overflow
  );
endinterface

// File: rtl/mult_8bit_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier for the ULA.
// One add-and-shift per clock through a single 8-bit adder.
module full_adder_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};
endmodule

module mult_8bit_seq (
  input  logic           clk,
  input  logic           rst_n,
  mult_8bit_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  m;
  logic [7:0]  q;
  logic [7:0]  acc;
  logic [3:0]  cnt;
  logic [7:0]  addend;
  logic [7:0]  sum;
  logic        cout;
  logic [7:0]  acc_nxt;
  logic [7:0]  q_nxt;
  logic [15:0] product;
  logic        overflow;

  assign addend = q[0] ? m : 8'h00;

  full_adder_8bit u_fa (
    .A    (acc),
    .B    (addend),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // Carry is kept as the shift-in bit so the 16-bit result stays exact
  assign acc_nxt = {cout, sum[7:1]};
  assign q_nxt   = {sum[0], q[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (cnt == 4'd7) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m        <= 8'h00;
      q        <= 8'h00;
      acc      <= 8'h00;
      cnt      <= 4'd0;
      product  <= 16'h0000;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            m   <= bus.A;
            q   <= bus.B;
            acc <= 8'h00;
            cnt <= 4'd0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + 4'd1;
          // Result registers load on the final shift so they land with done
          if (cnt == 4'd7) begin
            product  <= {acc_nxt, q_nxt};
            overflow <= |acc_nxt;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.Product  = product;
  assign bus.Overflow = overflow;
endmodule
